i2c_target: RTL

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_bus_sync.sv | 85 ++++++++
 rtl/i2c_target.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by i2c_target and i2c_manager.
// Contents: address/data widths, the R/W bit encoding and the target FSM state type.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    // Value of the R/W bit (LSB of the address byte) that requests a read.
    localparam logic I2C_RW_READ = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C bus front end: synchronizes SCL/SDA, filters glitches when I2C_TARGET_GLITCH_FILTER_EN
// is defined, and reports SCL edges plus START/STOP conditions in the clk domain.
module i2c_bus_sync (
    input  logic i_clk,
    input  logic i_n_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_sclRise,
    output logic o_sclFall,
    output logic o_start,
    output logic o_stop
);

    logic [1:0] r_sclSync;
    logic [1:0] r_sdaSync;
    logic       r_sclPrev;
    logic       r_sdaPrev;
    logic       w_scl;
    logic       w_sda;

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_sclSync <= 2'b11;
            r_sdaSync <= 2'b11;
        end else begin
            r_sclSync <= {r_sclSync[0], i_scl};
            r_sdaSync <= {r_sdaSync[0], i_sda};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] r_sclHist;
    logic [1:0] r_sdaHist;
    logic       r_sclFilt;
    logic       r_sdaFilt;

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_sclHist <= 2'b11;
            r_sdaHist <= 2'b11;
            r_sclFilt <= 1'b1;
            r_sdaFilt <= 1'b1;
        end else begin
            r_sclHist <= {r_sclHist[0], r_sclSync[1]};
            r_sdaHist <= {r_sdaHist[0], r_sdaSync[1]};
            r_sclFilt <= w_scl;
            r_sdaFilt <= w_sda;
        end
    end

    // A new level is accepted only once the newest sample and the two before it agree.
    always_comb begin
        w_scl = r_sclFilt;
        w_sda = r_sdaFilt;
        if ((r_sclSync[1] == r_sclHist[0]) && (r_sclSync[1] == r_sclHist[1])) begin
            w_scl = r_sclSync[1];
        end
        if ((r_sdaSync[1] == r_sdaHist[0]) && (r_sdaSync[1] == r_sdaHist[1])) begin
            w_sda = r_sdaSync[1];
        end
    end
`else
    assign w_scl = r_sclSync[1];
    assign w_sda = r_sdaSync[1];
`endif

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_sclPrev <= 1'b1;
            r_sdaPrev <= 1'b1;
        end else begin
            r_sclPrev <= w_scl;
            r_sdaPrev <= w_sda;
        end
    end

    assign o_sda     = w_sda;
    assign o_sclRise = w_scl & ~r_sclPrev;
    assign o_sclFall = ~w_scl & r_sclPrev;
    // SCL must be high on both samples so an SDA edge next to an SCL edge is not misread.
    assign o_start   = w_scl & r_sclPrev & r_sdaPrev & ~w_sda;
    assign o_stop    = w_scl & r_sclPrev & ~r_sdaPrev & w_sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target with an auto-incrementing 8-bit register pointer and a one-clk write strobe.
// Define I2C_TARGET_GLITCH_FILTER_EN to add the SCL/SDA glitch filter in i2c_bus_sync.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] DEV_ADDR = 7'h48,
    parameter logic [I2C_DATA_W-1:0] PTR_RST  = 8'h00
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [I2C_DATA_W-1:0] reg_addr,
    output logic [I2C_DATA_W-1:0] reg_wdata,
    output logic                  reg_we,
    input  logic [I2C_DATA_W-1:0] reg_rdata,
    output logic                  busy
);

    logic w_sda;
    logic w_sclRise;
    logic w_sclFall;
    logic w_start;
    logic w_stop;

    i2c_bus_sync u_bus_sync (
        .i_clk     (clk),
        .i_n_rst   (n_rst),
        .i_scl     (scl),
        .i_sda     (sda),
        .o_sda     (w_sda),
        .o_sclRise (w_sclRise),
        .o_sclFall (w_sclFall),
        .o_start   (w_start),
        .o_stop    (w_stop)
    );

    i2c_state_t            r_state;
    logic [3:0]            r_bitCnt;
    logic [I2C_DATA_W-1:0] r_shift;
    logic [I2C_DATA_W-1:0] r_ptr;
    logic [I2C_DATA_W-1:0] r_wdata;
    logic                  r_we;
    logic                  r_sdaOe;
    logic                  r_busy;

    i2c_state_t            w_stateNext;
    logic [3:0]            w_bitCntNext;
    logic [I2C_DATA_W-1:0] w_shiftNext;
    logic [I2C_DATA_W-1:0] w_ptrNext;
    logic [I2C_DATA_W-1:0] w_wdataNext;
    logic                  w_weNext;
    logic                  w_sdaOeNext;
    logic                  w_busyNext;
    logic [I2C_DATA_W-1:0] w_byte;
    logic                  w_addrMatch;

    assign w_byte      = {r_shift[I2C_DATA_W-2:0], w_sda};
    assign w_addrMatch = (r_shift[I2C_DATA_W-1:1] == DEV_ADDR);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            r_bitCnt <= '0;
            r_shift  <= '0;
            r_ptr    <= PTR_RST;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_sdaOe  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_bitCnt <= w_bitCntNext;
            r_shift  <= w_shiftNext;
            r_ptr    <= w_ptrNext;
            r_wdata  <= w_wdataNext;
            r_we     <= w_weNext;
            r_sdaOe  <= w_sdaOeNext;
            r_busy   <= w_busyNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_bitCntNext = r_bitCnt;
        w_shiftNext  = r_shift;
        w_ptrNext    = r_ptr;
        w_wdataNext  = r_wdata;
        w_weNext     = 1'b0;
        w_sdaOeNext  = r_sdaOe;
        w_busyNext   = r_busy;

        if (r_we) begin
            w_ptrNext = r_ptr + 8'd1;
        end

        // Bus conditions override whatever byte is in flight, so a partial byte never commits.
        if (w_stop) begin
            w_stateNext = IDLE;
            w_sdaOeNext = 1'b0;
            w_busyNext  = 1'b0;
        end else if (w_start) begin
            w_stateNext  = ADDR;
            w_bitCntNext = '0;
            w_sdaOeNext  = 1'b0;
        end else begin
            case (r_state)
                IDLE, IGNORE: begin
                end

                ADDR, PTR, WDATA: begin
                    if (w_sclRise && (r_bitCnt < 4'd8)) begin
                        w_shiftNext  = w_byte;
                        w_bitCntNext = r_bitCnt + 4'd1;
                        if (r_bitCnt == 4'd7) begin
                            if (r_state == PTR) begin
                                w_ptrNext = w_byte;
                            end
                            if (r_state == WDATA) begin
                                w_weNext    = 1'b1;
                                w_wdataNext = w_byte;
                            end
                        end
                    end else if (w_sclFall && (r_bitCnt == 4'd8)) begin
                        w_bitCntNext = '0;
                        if (r_state == ADDR) begin
                            if (w_addrMatch) begin
                                w_stateNext = ADDR_ACK;
                                w_sdaOeNext = 1'b1;
                                w_busyNext  = 1'b1;
                            end else begin
                                w_stateNext = IGNORE;
                                w_sdaOeNext = 1'b0;
                                w_busyNext  = 1'b0;
                            end
                        end else begin
                            w_stateNext = (r_state == PTR) ? PTR_ACK : WDATA_ACK;
                            w_sdaOeNext = 1'b1;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (w_sclFall) begin
                        w_bitCntNext = '0;
                        if (r_shift[0] == I2C_RW_READ) begin
                            w_stateNext = RDATA;
                            w_shiftNext = reg_rdata;
                            w_sdaOeNext = ~reg_rdata[I2C_DATA_W-1];
                        end else begin
                            w_stateNext = PTR;
                            w_sdaOeNext = 1'b0;
                        end
                    end
                end

                PTR_ACK, WDATA_ACK: begin
                    if (w_sclFall) begin
                        w_stateNext  = WDATA;
                        w_bitCntNext = '0;
                        w_sdaOeNext  = 1'b0;
                    end
                end

                RDATA: begin
                    if (w_sclRise && (r_bitCnt < 4'd8)) begin
                        w_bitCntNext = r_bitCnt + 4'd1;
                    end else if (w_sclFall) begin
                        if (r_bitCnt == 4'd8) begin
                            w_stateNext  = RDATA_ACK;
                            w_sdaOeNext  = 1'b0;
                            w_ptrNext    = r_ptr + 8'd1;
                        end else begin
                            w_shiftNext  = {r_shift[I2C_DATA_W-2:0], 1'b0};
                            w_sdaOeNext  = ~r_shift[I2C_DATA_W-2];
                        end
                    end
                end

                RDATA_ACK: begin
                    if (w_sclRise && w_sda) begin
                        w_stateNext = IGNORE;
                        w_sdaOeNext = 1'b0;
                        w_busyNext  = 1'b0;
                    end else if (w_sclFall) begin
                        w_stateNext  = RDATA;
                        w_bitCntNext = '0;
                        w_shiftNext  = reg_rdata;
                        w_sdaOeNext  = ~reg_rdata[I2C_DATA_W-1];
                    end
                end

                default: begin
                    w_stateNext = IDLE;
                    w_sdaOeNext = 1'b0;
                    w_busyNext  = 1'b0;
                end
            endcase
        end
    end

    assign sda       = r_sdaOe ? 1'b0 : 1'bz;
    assign reg_addr  = r_ptr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign busy      = r_busy;

endmodule
